pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Instruction-fetch sequencer of the ToyCPU front end. It owns the program counter, issues one outstanding fetch at a time to the memory controller, and buffers the returned instruction for decode. On a taken branch or jump, signalled by the branch controller's `special_pc_flag`, it redirects to the target and discards any wrong-path fetch still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global ready. When 0, all state freezes and every other input is ignored.
- `special_pc_flag`  in  1  redirect request from the branch controller.
- `redirect_pc`  in  32  redirect target. Sampled only when `special_pc_flag`=1.
- `fetch_req`  out  1  fetch request to the memory controller.
- `fetch_addr`  out  32  fetch address. Word aligned; stable while `fetch_req`=1.
- `fetch_done`  in  1  single-cycle pulse: the request is complete and `fetch_data` is valid.
- `fetch_data`  in  32  returned instruction word.
- `inst_valid`  out  1  buffered instruction is presented to decode.
- `inst`  out  32  buffered instruction.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decode accepts the instruction.

## Operation
- **State register**, three states:
  - FETCH: `fetch_req`=1, `fetch_addr`=pc.
  - SQUASH: `fetch_req`=1, `fetch_addr`=the stale pc; the request is kept alive until `fetch_done`.
  - HOLD: `fetch_req`=0, `inst_valid`=1.
- **FETCH:**
  - `special_pc_flag` & `fetch_done`: discard data; pc<=target; stay in FETCH.
  - `special_pc_flag` & !`fetch_done`: pend<=target; go to SQUASH. The memory interface cannot cancel a request.
  - `fetch_done` only: inst<=`fetch_data`; inst_pc<=pc; pc<=pc+4; go to HOLD.
- **SQUASH:**
  - A new `special_pc_flag` overwrites pend (latest wins).
  - On `fetch_done`: discard data; pc<=(`special_pc_flag` ? target : pend); go to FETCH.
- **HOLD:**
  - `special_pc_flag`: pc<=target; go to FETCH. This has priority over `inst_ready`.
  - Otherwise, if `inst_ready`: go to FETCH.
  - If `inst_ready` and redirect coincide, decode sees the handshake but must flush on the same redirect. The sequencer does not mask `inst_valid`.
- **Target alignment:** every target has bits [1:0] forced to 0 before it is stored.
- **PC arithmetic:** pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- **Stall:** `rdy_in`=0 holds all registers and outputs. `fetch_done`, `special_pc_flag` and `inst_ready` are ignored in that cycle. The memory controller is gated by the same `rdy_in`.
- **Reset:** applies on any cycle, including mid-fetch or in SQUASH. The pending fetch is abandoned, and the memory controller is reset by the same `rst`.

## Timing
- Reset values, from the edge at which `rst` is sampled high:
  - state=FETCH, pc=`RESET_PC`, pend=0.
  - `fetch_req`=1, `fetch_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
- All outputs are decoded from registers. There is no combinational path from inputs to outputs.
- Delivery latency: `fetch_done` in cycle t gives `inst_valid`=1 in cycle t+1.
- Next request: the cycle after an accepting `inst_ready`, `fetch_req`=1 with the next address.
- Peak throughput: one instruction per 2 cycles plus memory latency.
- Redirect in FETCH with `fetch_done`, or in HOLD: `fetch_addr`=target in the next cycle.
- Redirect in FETCH without `fetch_done`: the target is issued the cycle after the stale `fetch_done`.
- No `inst_valid` pulse ever results from a discarded fetch.

## Configuration
- Macro: `PC_FETCH_SEQ_PERF_EN`.
- **Defined:**
  - Adds output `perf_inst_cnt` [31:0], which increments on each `inst_valid`&`inst_ready` with `rdy_in`=1.
  - Adds output `perf_squash_cnt` [31:0], which increments on each discarded `fetch_done` and each HOLD-state redirect.
  - Both counters reset to 0, wrap modulo 2^32, and freeze when `rdy_in`=0.
- **Undefined:** the ports and counters are absent, and functional behaviour is identical.

## Test plan
- **Reset and sequential delivery:** `RESET_PC`=0, release `rst`; expect `fetch_req`=1, `fetch_addr`=0. Pulse `fetch_done` with data 32'h0000_0013; next cycle expect `inst_valid`=1, `inst`=32'h13, `inst_pc`=0, `fetch_req`=0. Assert `inst_ready`; next cycle expect `fetch_addr`=4.
- **Backpressure:** `inst_ready`=0 for 3 cycles in HOLD → `inst`/`inst_pc` stable, `fetch_req`=0 throughout; accept → `fetch_addr`=pc+4.
- **Squash in flight:** fetch at 8 outstanding, redirect to 32'h100 and then 32'h200 before `fetch_done` → stale data discarded with no `inst_valid`; next cycle `fetch_addr`=32'h200.
- **Coincident redirect and done:** redirect to 32'h100 in the same cycle as `fetch_done` → no `inst_valid`; next cycle `fetch_addr`=32'h100.
- **Redirect in HOLD:** redirect to misaligned 32'h103 → next cycle `inst_valid`=0, `fetch_addr`=32'h100.
- **Stall and wrap:** `rdy_in`=0 with a `fetch_done` pulse → ignored, outputs frozen. With pc=32'hFFFF_FFFC, a delivered instruction → next `fetch_addr`=0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, keeps one fetch outstanding, buffers the result for decode.
// Optional performance counters are enabled with `define PC_FETCH_SEQ_PERF_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        special_pc_flag,
  input  logic [31:0] redirect_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_done,
  input  logic [31:0] fetch_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef PC_FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_SQUASH = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend;

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  assign fetch_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      pend       <= '0;
      fetch_req  <= 1'b1;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (rdy_in) begin
      unique case (state)
        S_FETCH: begin
          if (special_pc_flag && fetch_done) begin
            pc <= align_target(redirect_pc);
          end else if (special_pc_flag) begin
            // The memory side cannot cancel, so ride out the stale request.
            pend  <= align_target(redirect_pc);
            state <= S_SQUASH;
          end else if (fetch_done) begin
            inst       <= fetch_data;
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            state      <= S_HOLD;
            fetch_req  <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        S_SQUASH: begin
          if (special_pc_flag) pend <= align_target(redirect_pc);
          if (fetch_done) begin
            pc    <= special_pc_flag ? align_target(redirect_pc) : pend;
            state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (special_pc_flag) begin
            pc         <= align_target(redirect_pc);
            state      <= S_FETCH;
            fetch_req  <= 1'b1;
            inst_valid <= 1'b0;
          end else if (inst_ready) begin
            state      <= S_FETCH;
            fetch_req  <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state      <= S_FETCH;
          fetch_req  <= 1'b1;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_SEQ_PERF_EN
  logic squash_evt;

  always_comb begin
    squash_evt = 1'b0;
    unique case (state)
      S_FETCH:  squash_evt = special_pc_flag && fetch_done;
      S_SQUASH: squash_evt = fetch_done;
      S_HOLD:   squash_evt = special_pc_flag;
      default:  squash_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_cnt   <= '0;
      perf_squash_cnt <= '0;
    end else if (rdy_in) begin
      if (inst_valid && inst_ready) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (squash_evt) perf_squash_cnt <= perf_squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer (default build, RESET_PC = 0).
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_in = 1'b1;
  logic        special_pc_flag = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .special_pc_flag(special_pc_flag), .redirect_pc(redirect_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_data(fetch_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  typedef struct {
    logic        rst, rdy, flag;
    logic [31:0] tgt;
    logic        done;
    logic [31:0] data;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] t,
                              input logic d, input logic [31:0] dat, input logic rd,
                              input logic ereq, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] einst, input logic [31:0] eipc);
    vec_t v;
    v.rst = r; v.rdy = 1'b1; v.flag = f; v.tgt = t; v.done = d; v.data = dat; v.ready = rd;
    v.e_req = ereq; v.e_addr = eaddr; v.e_iv = eiv; v.e_inst = einst; v.e_ipc = eipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic f, input logic [31:0] t,
                       input logic d, input logic [31:0] dat, input logic rd);
    rst = r; rdy_in = rdy; special_pc_flag = f; redirect_pc = t;
    fetch_done = d; fetch_data = dat; inst_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic eiv, input logic [31:0] einst, input logic [31:0] eipc,
                            input logic chk_inst);
    chk({tag, " fetch_req"}, {31'd0, fetch_req}, {31'd0, ereq});
    if (ereq) chk({tag, " fetch_addr"}, fetch_addr, eaddr);
    chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, eiv});
    if (chk_inst) begin
      chk({tag, " inst"}, inst, einst);
      chk({tag, " inst_pc"}, inst_pc, eipc);
    end
  endtask

  initial begin
    //            rst flag tgt            done data           rdy  req addr          iv inst           ipc
    tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0000_0013,  0,   0, 32'h0,         1, 32'h13,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h4,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0000_0093,  0,   0, 32'h0,         1, 32'h93,         32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,         1, 32'h93,         32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,         1, 32'h93,         32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,         1, 32'h93,         32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 1, 32'h100,        0, 32'h0,          0,   1, 32'h8,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 1, 32'h200,        0, 32'h0,          0,   1, 32'h8,         0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'hDEAD_DEAD,  0,   1, 32'h200,       0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 1, 32'h100,        1, 32'hBEEF_BEEF,  0,   1, 32'h100,       0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0000_0011,  0,   0, 32'h0,         1, 32'h11,         32'h100));
    tbl.push_back(mk(0, 1, 32'h103,        0, 32'h0,          1,   1, 32'h100,       0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 1, 32'h300,        0, 32'h0,          0,   1, 32'h100,       0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 1, 32'h401,        1, 32'hCAFE_CAFE,  0,   1, 32'h400,       0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0000_0022,  0,   0, 32'h0,         1, 32'h22,         32'h400));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h404,       0, 32'h0,          32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].flag, tbl[i].tgt, tbl[i].done, tbl[i].data, tbl[i].ready);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv,
                 tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_iv || tbl[i].rst);
    end

    // Stall: fetch_done and a redirect while rdy_in=0 must be ignored.
    drive(0, 0, 1, 32'h800, 1, 32'h5555_5555, 1);
    expect_out("stall", 1, 32'h404, 0, 32'h0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
    expect_out("post_stall", 1, 32'h404, 0, 32'h0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 1, 32'h0000_0066, 0);
    expect_out("deliver_404", 0, 32'h0, 1, 32'h66, 32'h404, 1);
    // Stall in HOLD: acceptance ignored, buffer frozen.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
    expect_out("stall_hold", 0, 32'h0, 1, 32'h66, 32'h404, 1);

    // Wrap: redirect to the top word, deliver, next address wraps to 0.
    drive(0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0);
    expect_out("to_top", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 1, 32'h0000_0077, 0);
    expect_out("top_inst", 0, 32'h0, 1, 32'h77, 32'hFFFF_FFFC, 1);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
    expect_out("wrap", 1, 32'h0, 0, 32'h0, 32'h0, 0);

    // Reset while squashing abandons the pending redirect.
    drive(0, 1, 1, 32'h500, 0, 32'h0, 0);
    expect_out("squash0", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
    expect_out("rst_sq", 1, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(0, 1, 0, 32'h0, 1, 32'h0000_0088, 0);
    expect_out("after_rst", 0, 32'h0, 1, 32'h88, 32'h0, 1);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
    expect_out("after_rst_next", 1, 32'h4, 0, 32'h0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
